md_rs: RTL and testbench

MD_RS -- requirements
Module: md_rs

---
 rtl/md_rs.sv | 148 ++++++++++++++
 tb/tb_md_rs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_rs.sv
// Reservation station for the RV32M multiply/divide unit: holds dispatched
// instructions, wakes operands from the CDB and issues one op at a time.
module md_rs #(
    parameter int ROB_DEPTH = 4,
    parameter int RS_DEPTH  = 4,
    localparam int TW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          dispatch_valid,
    output logic          dispatch_ready,
    input  logic [31:0]   dispatch_instr,
    input  logic [TW-1:0] dispatch_rob_tag,
    input  logic          dispatch_rs1_ready,
    input  logic          dispatch_rs2_ready,
    input  logic [31:0]   dispatch_rs1_v,
    input  logic [31:0]   dispatch_rs2_v,
    input  logic [TW-1:0] dispatch_rs1_tag,
    input  logic [TW-1:0] dispatch_rs2_tag,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_rob,
    input  logic [31:0]   cdb_value,
    output logic          md_en,
    output logic [31:0]   md_instr,
    output logic [31:0]   md_rs1_v,
    output logic [31:0]   md_rs2_v,
    output logic [TW-1:0] md_rob_tag,
    input  logic          md_resp
);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CW = $clog2(RS_DEPTH + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic [RS_DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
    logic [31:0]         r_instr [RS_DEPTH];
    logic [31:0]         r_v1    [RS_DEPTH];
    logic [31:0]         r_v2    [RS_DEPTH];
    logic [TW-1:0]       r_tag   [RS_DEPTH];
    logic [TW-1:0]       r_t1    [RS_DEPTH];
    logic [TW-1:0]       r_t2    [RS_DEPTH];

    state_t        r_state, w_next;
    logic [31:0]   r_md_instr, r_md_rs1, r_md_rs2;
    logic [TW-1:0] r_md_tag;

    logic [IW-1:0] w_free_idx, w_sel_idx;
    logic          w_sel_found, w_issue, w_accept;
    logic [CW-1:0] w_count;

    // Lowest index wins for both allocation and selection; scan downward so
    // the last hit is the lowest.
    always_comb begin
        w_free_idx  = '0;
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        w_count     = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i])
                w_free_idx = IW'(i);
            if (r_valid[i] && r_rdy1[i] && r_rdy2[i]) begin
                w_sel_idx   = IW'(i);
                w_sel_found = 1'b1;
            end
            w_count = w_count + CW'(r_valid[i]);
        end
    end

    assign dispatch_ready = (w_count < CW'(RS_DEPTH));
    assign w_accept       = dispatch_valid && dispatch_ready;

    always_ff @(posedge clk) begin
        if (rst || flush)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_sel_found) w_next = S_BUSY;
            S_BUSY: if (md_resp)     w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_comb begin
        md_en   = (r_state == S_BUSY);
        w_issue = (r_state == S_IDLE) && w_sel_found;
    end

    // The issuing entry is still marked valid for allocation this cycle, so
    // a same-cycle dispatch always lands in a different slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (cdb_valid && r_valid[i]) begin
                    if (!r_rdy1[i] && r_t1[i] == cdb_rob) begin
                        r_rdy1[i] <= 1'b1;
                        r_v1[i]   <= cdb_value;
                    end
                    if (!r_rdy2[i] && r_t2[i] == cdb_rob) begin
                        r_rdy2[i] <= 1'b1;
                        r_v2[i]   <= cdb_value;
                    end
                end
            end
            if (w_issue)
                r_valid[w_sel_idx] <= 1'b0;
            if (w_accept) begin
                r_valid[w_free_idx] <= 1'b1;
                r_instr[w_free_idx] <= dispatch_instr;
                r_tag[w_free_idx]   <= dispatch_rob_tag;
                r_t1[w_free_idx]    <= dispatch_rs1_tag;
                r_t2[w_free_idx]    <= dispatch_rs2_tag;
                r_rdy1[w_free_idx]  <= dispatch_rs1_ready ||
                                       (cdb_valid && dispatch_rs1_tag == cdb_rob);
                r_rdy2[w_free_idx]  <= dispatch_rs2_ready ||
                                       (cdb_valid && dispatch_rs2_tag == cdb_rob);
                r_v1[w_free_idx]    <= dispatch_rs1_ready ? dispatch_rs1_v : cdb_value;
                r_v2[w_free_idx]    <= dispatch_rs2_ready ? dispatch_rs2_v : cdb_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_md_instr <= '0;
            r_md_rs1   <= '0;
            r_md_rs2   <= '0;
            r_md_tag   <= '0;
        end else if (w_issue) begin
            r_md_instr <= r_instr[w_sel_idx];
            r_md_rs1   <= r_v1[w_sel_idx];
            r_md_rs2   <= r_v2[w_sel_idx];
            r_md_tag   <= r_tag[w_sel_idx];
        end
    end

    assign md_instr   = r_md_instr;
    assign md_rs1_v   = r_md_rs1;
    assign md_rs2_v   = r_md_rs2;
    assign md_rob_tag = r_md_tag;
endmodule

// File: tb/tb_md_rs.sv
// Bench for md_rs: a cycle model of the station checked every cycle, plus
// directed scenarios with hand-derived literal expectations.
module tb_md_rs;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic        dispatch_valid, dispatch_ready;
    logic [31:0] dispatch_instr;
    logic [1:0]  dispatch_rob_tag;
    logic        dispatch_rs1_ready, dispatch_rs2_ready;
    logic [31:0] dispatch_rs1_v, dispatch_rs2_v;
    logic [1:0]  dispatch_rs1_tag, dispatch_rs2_tag;
    logic        cdb_valid;
    logic [1:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        md_en;
    logic [31:0] md_instr, md_rs1_v, md_rs2_v;
    logic [1:0]  md_rob_tag;
    logic        md_resp;

    localparam logic [31:0] MUL = 32'h0220_80B3;
    localparam logic [31:0] DIV = 32'h0220_C0B3;

    md_rs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_instr(dispatch_instr), .dispatch_rob_tag(dispatch_rob_tag),
        .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_rs1_v(dispatch_rs1_v), .dispatch_rs2_v(dispatch_rs2_v),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .md_en(md_en), .md_instr(md_instr), .md_rs1_v(md_rs1_v),
        .md_rs2_v(md_rs2_v), .md_rob_tag(md_rob_tag), .md_resp(md_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a list of held instructions and one unit slot.
    typedef struct {
        bit          v;
        logic [31:0] instr;
        logic [1:0]  tag;
        bit          r1, r2;
        logic [31:0] v1, v2;
        logic [1:0]  t1, t2;
    } ent_t;

    ent_t        m_e[4];
    bit          m_busy;
    logic [31:0] m_instr, m_rs1, m_rs2;
    logic [1:0]  m_tag;
    int          m_cnt;

    always @(posedge clk) begin
        int sel, fr, cnt;
        if (rst || flush) begin
            for (int i = 0; i < 4; i++) m_e[i].v = 0;
            m_busy = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0; m_tag = 0;
        end else begin
            sel = -1;
            if (!m_busy)
                for (int i = 0; i < 4; i++)
                    if (sel < 0 && m_e[i].v && m_e[i].r1 && m_e[i].r2) sel = i;
            fr = -1; cnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_e[i].v) cnt++;
                else if (fr < 0) fr = i;
            end
            if (cdb_valid)
                for (int i = 0; i < 4; i++) if (m_e[i].v) begin
                    if (!m_e[i].r1 && m_e[i].t1 == cdb_rob) begin m_e[i].r1 = 1; m_e[i].v1 = cdb_value; end
                    if (!m_e[i].r2 && m_e[i].t2 == cdb_rob) begin m_e[i].r2 = 1; m_e[i].v2 = cdb_value; end
                end
            if (sel >= 0) begin
                m_busy = 1; m_instr = m_e[sel].instr; m_rs1 = m_e[sel].v1;
                m_rs2 = m_e[sel].v2; m_tag = m_e[sel].tag; m_e[sel].v = 0;
            end else if (m_busy && md_resp) begin
                m_busy = 0;
            end
            if (dispatch_valid && cnt < 4) begin
                m_e[fr].v     = 1;
                m_e[fr].instr = dispatch_instr;
                m_e[fr].tag   = dispatch_rob_tag;
                m_e[fr].t1    = dispatch_rs1_tag;
                m_e[fr].t2    = dispatch_rs2_tag;
                m_e[fr].r1    = dispatch_rs1_ready || (cdb_valid && dispatch_rs1_tag == cdb_rob);
                m_e[fr].r2    = dispatch_rs2_ready || (cdb_valid && dispatch_rs2_tag == cdb_rob);
                m_e[fr].v1    = dispatch_rs1_ready ? dispatch_rs1_v : cdb_value;
                m_e[fr].v2    = dispatch_rs2_ready ? dispatch_rs2_v : cdb_value;
            end
        end
        m_cnt = 0;
        for (int i = 0; i < 4; i++) if (m_e[i].v) m_cnt++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_dready", {31'b0, dispatch_ready}, {31'b0, m_cnt < 4});
            check("m_en", {31'b0, md_en}, {31'b0, m_busy});
            check("m_instr", md_instr, m_instr);
            check("m_rs1", md_rs1_v, m_rs1);
            check("m_rs2", md_rs2_v, m_rs2);
            check("m_tag", {30'b0, md_rob_tag}, {30'b0, m_tag});
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        dispatch_valid = 0; cdb_valid = 0; md_resp = 0; flush = 0;
    endtask

    task automatic disp(input logic [31:0] ins, input logic [1:0] tag,
                        input bit r1, input logic [31:0] v1, input logic [1:0] t1,
                        input bit r2, input logic [31:0] v2, input logic [1:0] t2);
        dispatch_valid = 1; dispatch_instr = ins; dispatch_rob_tag = tag;
        dispatch_rs1_ready = r1; dispatch_rs1_v = v1; dispatch_rs1_tag = t1;
        dispatch_rs2_ready = r2; dispatch_rs2_v = v2; dispatch_rs2_tag = t2;
    endtask

    task automatic resp_cycle();
        md_resp = 1; step(); md_resp = 0;
    endtask

    initial begin
        rst = 1; idle_in();
        disp(0, 0, 0, 0, 0, 0, 0, 0); dispatch_valid = 0;
        cdb_rob = 0; cdb_value = 0;
        step(); step();
        rst = 0; chk_en = 1;
        check("rst_dready", {31'b0, dispatch_ready}, 32'd1);
        check("rst_en", {31'b0, md_en}, 32'd0);
        check("rst_instr", md_instr, 32'd0);

        // Ready MUL: md_en two cycles after dispatch, drops the cycle after resp.
        disp(MUL, 2, 1, 7, 0, 1, 6, 0); step(); idle_in();
        check("mul_c1_en", {31'b0, md_en}, 32'd0);
        step();
        check("mul_c2_en", {31'b0, md_en}, 32'd1);
        check("mul_rs1", md_rs1_v, 32'd7);
        check("mul_rs2", md_rs2_v, 32'd6);
        check("mul_tag", {30'b0, md_rob_tag}, 32'd2);
        check("mul_instr", md_instr, MUL);
        step(); step(); step();
        resp_cycle();
        check("mul_c6_en", {31'b0, md_en}, 32'd0);
        md_resp = 1; step(); md_resp = 0;
        check("idle_resp_en", {31'b0, md_en}, 32'd0);

        // DIV waiting on tag 3, woken by the CDB.
        disp(DIV, 1, 1, 20, 0, 0, 0, 3); step(); idle_in();
        step(); step();
        check("div_wait_en", {31'b0, md_en}, 32'd0);
        cdb_valid = 1; cdb_rob = 3; cdb_value = 0; step(); idle_in();
        check("div_wake_en", {31'b0, md_en}, 32'd0);
        step();
        check("div_issue_en", {31'b0, md_en}, 32'd1);
        check("div_rs1", md_rs1_v, 32'd20);
        check("div_rs2", md_rs2_v, 32'd0);
        resp_cycle(); step();

        // Dispatch-time bypass from the CDB.
        disp(MUL, 0, 0, 0, 1, 1, 5, 0);
        cdb_valid = 1; cdb_rob = 1; cdb_value = 32'hDEADBEEF;
        step(); idle_in(); step();
        check("byp_en", {31'b0, md_en}, 32'd1);
        check("byp_rs1", md_rs1_v, 32'hDEADBEEF);
        check("byp_rs2", md_rs2_v, 32'd5);
        resp_cycle(); step();

        // Younger ready entry issues ahead of an older waiting one.
        disp(DIV, 0, 0, 0, 2, 1, 9, 0); step();
        disp(MUL, 1, 1, 31, 0, 1, 32, 0); step(); idle_in();
        step();
        check("ooo_rs1", md_rs1_v, 32'd31);
        cdb_valid = 1; cdb_rob = 2; cdb_value = 32'h44; resp_cycle(); idle_in();
        step();
        check("ooo_second_rs1", md_rs1_v, 32'h44);
        resp_cycle(); step();

        // Fill all four slots while busy; a fifth dispatch is dropped.
        disp(MUL, 0, 1, 10, 0, 1, 1, 0); step(); idle_in(); step();
        check("fill_busy", {31'b0, md_en}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            disp(MUL, 2'(k), 1, 32'(11 + k), 0, 1, 2, 0); step();
        end
        idle_in();
        check("fill_full", {31'b0, dispatch_ready}, 32'd0);
        disp(MUL, 3, 1, 99, 0, 1, 2, 0); step(); idle_in();
        check("fill_drop", {31'b0, dispatch_ready}, 32'd0);
        resp_cycle();
        check("fill_gap_en", {31'b0, md_en}, 32'd0);
        step();
        check("fill_e0_rs1", md_rs1_v, 32'd11);
        check("fill_free", {31'b0, dispatch_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            resp_cycle(); step();
            check("drain_rs1", md_rs1_v, 32'(12 + k));
        end

        // Flush with a same-cycle dispatch and response.
        step();
        disp(MUL, 1, 1, 55, 0, 1, 0, 0); step(); idle_in();
        flush = 1; md_resp = 1; disp(MUL, 2, 1, 66, 0, 1, 0, 0);
        step(); idle_in();
        check("fl_en", {31'b0, md_en}, 32'd0);
        check("fl_dready", {31'b0, dispatch_ready}, 32'd1);
        check("fl_instr", md_instr, 32'd0);
        step(); step(); step();
        check("fl_no_issue", {31'b0, md_en}, 32'd0);

        // Reset while busy, then a stale response.
        disp(DIV, 3, 1, 77, 0, 1, 3, 0); step(); idle_in(); step();
        check("rb_busy", {31'b0, md_en}, 32'd1);
        rst = 1; step(); rst = 0;
        check("rb_en", {31'b0, md_en}, 32'd0);
        check("rb_rs1", md_rs1_v, 32'd0);
        check("rb_tag", {30'b0, md_rob_tag}, 32'd0);
        resp_cycle(); step();
        check("rb_stale_en", {31'b0, md_en}, 32'd0);
        check("rb_stale_rs1", md_rs1_v, 32'd0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
